tcam_rule_ctrl: RTL

TCAM_RULE_CTRL -- requirements
Module: tcam_rule_ctrl

---
 rtl/tcam_pkg.sv | 47 ++++
 rtl/tcam_row_gen.sv | 28 ++
 rtl/tcam_rule_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/tcam_pkg.sv
// Shared types and constants for the TCAM rule controller and its row-word generator.
package tcam_pkg;

    localparam int KEY_W   = 28;
    localparam int CHUNK_W = 7;
    localparam int N_ROWS  = 512;
    localparam int ROW_W   = 9;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);

    typedef enum logic [1:0] {
        OP_WRITE  = 2'd0,
        OP_INVAL  = 2'd1,
        OP_SEARCH = 2'd2,
        OP_NOP    = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SWEEP,
        ST_SRCH,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [KEY_W-1:0] value;
        logic [KEY_W-1:0] mask;
    } rule_t;

    // Chunk 0 is the most significant 7 bits of the key.
    function automatic logic [CHUNK_W-1:0] chunk_sel(input logic [KEY_W-1:0] v,
                                                     input logic [1:0]       c);
        logic [CHUNK_W-1:0] r;
        r = '0;
        case (c)
            2'd0: r = v[27:21];
            2'd1: r = v[20:14];
            2'd2: r = v[13:7];
            2'd3: r = v[6:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tcam_row_gen.sv
// Combinational row-word generator: for one array row {chunk, chunk value},
// bit r is set when rule r is valid and matches that chunk value under its mask.
module tcam_row_gen
    import tcam_pkg::*;
#(
    parameter int N_RULES = 32
) (
    input  logic [ROW_W-1:0]      in_row,
    input  rule_t [N_RULES-1:0]   in_rules,
    output logic [N_RULES-1:0]    out_word
);

    logic [1:0]         w_chunk;
    logic [CHUNK_W-1:0] w_x;

    assign w_chunk = in_row[ROW_W-1 -: 2];
    assign w_x     = in_row[CHUNK_W-1:0];

    always_comb begin
        out_word = '0;
        for (int r = 0; r < N_RULES; r++) begin
            out_word[r] = in_rules[r].valid &&
                (((chunk_sel(in_rules[r].value, w_chunk) ^ w_x) &
                  ~chunk_sel(in_rules[r].mask, w_chunk)) == '0);
        end
    end

endmodule

// File: rtl/tcam_rule_ctrl.sv
// Rule-table controller for a chunked TCAM array: keeps a shadow rule table,
// rewrites all 512 array rows after every rule change and runs key searches.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | clear sweep after reset, writes 0 to rows 0..511
// ST_IDLE  | ready for a request
// ST_SWEEP | rewrite rows 0..511 from the updated shadow table
// ST_SRCH  | drive search key to the array
// ST_WAIT  | hold search drive, capture priority-match at the end
// ST_RESP  | present result until consumed
module tcam_rule_ctrl
    import tcam_pkg::*;
#(
    parameter int N_RULES = 32,
    parameter int KEY_W   = 28
) (
    input  logic                         in_clk,
    input  logic                         in_rst,
    input  logic                         in_req_valid,
    output logic                         out_req_ready,
    input  logic [1:0]                   in_req_op,
    input  logic [$clog2(N_RULES)-1:0]   in_req_idx,
    input  logic [KEY_W-1:0]             in_req_value,
    input  logic [KEY_W-1:0]             in_req_mask,
    output logic                         out_resp_valid,
    input  logic                         in_resp_ready,
    output logic [$clog2(N_RULES):0]     out_resp_pma,
    output logic                         out_csb,
    output logic                         out_web,
    output logic [3:0]                   out_wmask,
    output logic [KEY_W-1:0]             out_addr,
    output logic [N_RULES-1:0]           out_wdata,
    input  logic [$clog2(N_RULES):0]     in_pma
);

    state_e                     r_state;
    state_e                     w_state_nxt;
    logic [ROW_W-1:0]           r_row;
    rule_t [N_RULES-1:0]        r_rules;
    logic [KEY_W-1:0]           r_key;
    logic [$clog2(N_RULES):0]   r_pma;

    op_e                        w_op;
    logic                       w_accept;
    logic [N_RULES-1:0]         w_row_word;
    logic [KEY_W-1:0]           w_row_addr;

    assign w_op       = op_e'(in_req_op);
    assign w_accept   = in_req_valid && out_req_ready;
    assign w_row_addr = {{(KEY_W-ROW_W){1'b0}}, r_row};

    tcam_row_gen #(
        .N_RULES (N_RULES)
    ) u_row_gen (
        .in_row   (r_row),
        .in_rules (r_rules),
        .out_word (w_row_word)
    );

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state <= ST_INIT;
            r_row   <= '0;
            r_rules <= '0;
            r_key   <= '0;
            r_pma   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_INIT, ST_SWEEP: r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                ST_IDLE: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_WRITE:  r_rules[in_req_idx] <= {1'b1, in_req_value, in_req_mask};
                            OP_INVAL:  r_rules[in_req_idx].valid <= 1'b0;
                            OP_SEARCH: r_key <= in_req_value;
                            default: ;
                        endcase
                    end
                end
                ST_WAIT: r_pma <= in_pma;
                default: ;
            endcase
        end
    end

    assign out_resp_pma = r_pma;

    always_comb begin
        w_state_nxt    = r_state;
        out_req_ready  = 1'b0;
        out_resp_valid = 1'b0;
        out_csb        = 1'b1;
        out_web        = 1'b1;
        out_wmask      = 4'h0;
        out_addr       = '0;
        out_wdata      = '0;
        case (r_state)
            ST_INIT: begin
                // Array port stays idle while reset is still held.
                if (!in_rst) begin
                    out_csb   = 1'b0;
                    out_web   = 1'b0;
                    out_wmask = 4'hF;
                    out_addr  = w_row_addr;
                end
                if (r_row == ROW_LAST) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                out_req_ready = 1'b1;
                if (in_req_valid) begin
                    case (w_op)
                        OP_WRITE, OP_INVAL: w_state_nxt = ST_SWEEP;
                        OP_SEARCH:          w_state_nxt = ST_SRCH;
                        default:            w_state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_SWEEP: begin
                out_csb   = 1'b0;
                out_web   = 1'b0;
                out_wmask = 4'hF;
                out_addr  = w_row_addr;
                out_wdata = w_row_word;
                if (r_row == ROW_LAST) w_state_nxt = ST_IDLE;
            end
            ST_SRCH: begin
                out_csb     = 1'b0;
                out_addr    = r_key;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                out_csb     = 1'b0;
                out_addr    = r_key;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                out_resp_valid = 1'b1;
                if (in_resp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

endmodule
